// File: rtl/dmem_banked_if.sv
// Two-lane load/store bus for dmem_banked. The suffixes are seen from the memory side:
// _i is driven by the core (master) and _o is driven by the memory (slave).
interface dmem_banked_if;
    logic        p0_req_i;
    logic        p0_we_i;
    logic [1:0]  p0_size_i;
    logic        p0_unsigned_i;
    logic [31:0] p0_addr_i;
    logic [31:0] p0_wdata_i;
    logic        p0_ready_o;
    logic        p0_rvalid_o;
    logic [31:0] p0_rdata_o;
    logic        p0_misalign_o;

    logic        p1_req_i;
    logic        p1_we_i;
    logic [1:0]  p1_size_i;
    logic        p1_unsigned_i;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_wdata_i;
    logic        p1_ready_o;
    logic        p1_rvalid_o;
    logic [31:0] p1_rdata_o;
    logic        p1_misalign_o;

    modport master (
        output p0_req_i, p0_we_i, p0_size_i, p0_unsigned_i, p0_addr_i, p0_wdata_i,
        output p1_req_i, p1_we_i, p1_size_i, p1_unsigned_i, p1_addr_i, p1_wdata_i,
        input  p0_ready_o, p0_rvalid_o, p0_rdata_o, p0_misalign_o,
        input  p1_ready_o, p1_rvalid_o, p1_rdata_o, p1_misalign_o
    );

    modport slave (
        input  p0_req_i, p0_we_i, p0_size_i, p0_unsigned_i, p0_addr_i, p0_wdata_i,
        input  p1_req_i, p1_we_i, p1_size_i, p1_unsigned_i, p1_addr_i, p1_wdata_i,
        output p0_ready_o, p0_rvalid_o, p0_rdata_o, p0_misalign_o,
        output p1_ready_o, p1_rvalid_o, p1_rdata_o, p1_misalign_o
    );
endinterface

// File: rtl/dmem_banked.sv
// Two-port word-interleaved banked data memory with RISC-V size/sign handling and lane-0 priority.
// Optional macro DMEM_BANK_STATS_EN adds saturating conflict/access counters.
module dmem_banked #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    NUM_BANKS   = 4,
    parameter string INIT_FILE   = "dmem.mem"
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_banked_if.slave bus
`ifdef DMEM_BANK_STATS_EN
    ,
    output logic [31:0] conflict_cnt_o,
    output logic [31:0] access_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] BANK_MASK = AW'(NUM_BANKS - 1);

    // Word index = {row, bank}, so the flat array is already bank-interleaved.
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [1:0]    req_s, we_s, uns_s, mis_s, ready_s, acc_s;
    logic [1:0]    size_s [2];
    logic [31:0]   addr_s [2];
    logic [31:0]   wdata_s [2];
    logic [31:0]   wrep_s [2];
    logic [3:0]    be_s [2];
    logic [AW-1:0] widx_s [2];
    logic          conflict_s;

    logic [1:0]    rvalid_q, mis_q;
    logic [31:0]   rdata_q [2];

    logic          unused_s;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   wdata_rep = {4{wd[7:0]}};
            2'b01:   wdata_rep = {2{wd[15:0]}};
            default: wdata_rep = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_ext = {{24{b[7] & ~uns}}, b};
            2'b01:   load_ext = {{16{h[15] & ~uns}}, h};
            2'b10:   load_ext = word;
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

    assign req_s     = {bus.p1_req_i, bus.p0_req_i};
    assign we_s      = {bus.p1_we_i, bus.p0_we_i};
    assign uns_s     = {bus.p1_unsigned_i, bus.p0_unsigned_i};
    assign size_s[0] = bus.p0_size_i;
    assign size_s[1] = bus.p1_size_i;
    assign addr_s[0] = bus.p0_addr_i;
    assign addr_s[1] = bus.p1_addr_i;
    assign wdata_s[0] = bus.p0_wdata_i;
    assign wdata_s[1] = bus.p1_wdata_i;

    assign unused_s = ^{addr_s[0][31:AW+2], addr_s[1][31:AW+2]};

    // Address decode, alignment, conflict detection and handshake.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            widx_s[l] = addr_s[l][2 +: AW];
            mis_s[l]  = misaligned(size_s[l], addr_s[l][1:0]);
            be_s[l]   = byte_en(size_s[l], addr_s[l][1:0]);
            wrep_s[l] = wdata_rep(size_s[l], wdata_s[l]);
        end
        conflict_s = 1'b0;
        if (req_s == 2'b11 && mis_s == 2'b00 &&
            (widx_s[0] & BANK_MASK) == (widx_s[1] & BANK_MASK)) begin
            // Only two loads of the very same word may share a bank in one cycle.
            conflict_s = !(we_s == 2'b00 && widx_s[0] == widx_s[1]);
        end else begin
            conflict_s = 1'b0;
        end
        ready_s = {~conflict_s, 1'b1};
        acc_s   = req_s & ready_s;
    end

    assign bus.p0_ready_o    = ready_s[0];
    assign bus.p1_ready_o    = ready_s[1];
    assign bus.p0_rvalid_o   = rvalid_q[0];
    assign bus.p1_rvalid_o   = rvalid_q[1];
    assign bus.p0_rdata_o    = rdata_q[0];
    assign bus.p1_rdata_o    = rdata_q[1];
    assign bus.p0_misalign_o = mis_q[0];
    assign bus.p1_misalign_o = mis_q[1];

    // Byte-enabled store writes; granted stores on both lanes always target different banks.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (acc_s[l] && we_s[l] && !mis_s[l]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[l][b]) begin
                        mem_q[widx_s[l]][b*8 +: 8] <= wrep_s[l][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered responses: one pulse per accepted request, data read before same-edge writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            mis_q    <= 2'b00;
            for (int l = 0; l < 2; l++) begin
                rdata_q[l] <= 32'h0000_0000;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                rvalid_q[l] <= acc_s[l];
                mis_q[l]    <= acc_s[l] & mis_s[l];
                if (acc_s[l] && !we_s[l] && !mis_s[l]) begin
                    rdata_q[l] <= load_ext(mem_q[widx_s[l]], size_s[l], addr_s[l][1:0], uns_s[l]);
                end else begin
                    rdata_q[l] <= 32'h0000_0000;
                end
            end
        end
    end

`ifdef DMEM_BANK_STATS_EN
    logic [31:0] conflict_cnt_q, access_cnt_q;
    logic [32:0] access_sum_s;

    assign access_sum_s   = {1'b0, access_cnt_q} + 33'(acc_s[0]) + 33'(acc_s[1]);
    assign conflict_cnt_o = conflict_cnt_q;
    assign access_cnt_o   = access_cnt_q;

    // Saturating usage counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= 32'h0000_0000;
            access_cnt_q   <= 32'h0000_0000;
        end else begin
            if (conflict_s && conflict_cnt_q != 32'hFFFF_FFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 32'h0000_0001;
            end
            access_cnt_q <= access_sum_s[32] ? 32'hFFFF_FFFF : access_sum_s[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_dmem_banked.sv
// Directed self-checking bench for dmem_banked: reset, sub-word, dual-lane, conflicts,
// misalignment, address wrap and (with DMEM_BANK_STATS_EN) counters.
module tb_dmem_banked;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dmem_banked_if bus ();

`ifdef DMEM_BANK_STATS_EN
    logic [31:0] conflict_cnt, access_cnt;
    logic [31:0] conf_base, acc_base;
`endif

    dmem_banked #(.DEPTH_WORDS(4096), .NUM_BANKS(4), .INIT_FILE("")) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DMEM_BANK_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .access_cnt_o   (access_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
    endtask

    task automatic drive(input int lane, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (lane == 0) begin
            bus.p0_req_i = 1'b1; bus.p0_we_i = we; bus.p0_size_i = size;
            bus.p0_unsigned_i = uns; bus.p0_addr_i = addr; bus.p0_wdata_i = wdata;
        end else begin
            bus.p1_req_i = 1'b1; bus.p1_we_i = we; bus.p1_size_i = size;
            bus.p1_unsigned_i = uns; bus.p1_addr_i = addr; bus.p1_wdata_i = wdata;
        end
    endtask

    // Single lane-0 access: checks ready, then the N+1 response.
    task automatic access0(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_mis);
        drive(0, we, size, uns, addr, wdata);
        #1;
        chk({tag, "_ready"}, {31'd0, bus.p0_ready_o}, 32'd1);
        step();
        idle_all();
        chk({tag, "_rvalid"}, {31'd0, bus.p0_rvalid_o}, 32'd1);
        chk({tag, "_rdata"}, bus.p0_rdata_o, exp_data);
        chk({tag, "_mis"}, {31'd0, bus.p0_misalign_o}, {31'd0, exp_mis});
    endtask

    initial begin
        idle_all();
        drive(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        idle_all();

        // Reset held three cycles with toggling requests.
        for (int i = 0; i < 3; i++) begin
            bus.p0_req_i = (i % 2 == 0);
            bus.p1_req_i = (i % 2 == 1);
            step();
            chk("rst_rvalid", {30'd0, bus.p1_rvalid_o, bus.p0_rvalid_o}, 32'd0);
            chk("rst_rdata", bus.p0_rdata_o | bus.p1_rdata_o, 32'd0);
            chk("rst_mis", {30'd0, bus.p1_misalign_o, bus.p0_misalign_o}, 32'd0);
        end
        idle_all();
        rst_n = 1'b1;
        step();

        // First load after reset responds at N+1 (no image loaded, so data is not checked).
        drive(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        idle_all();
        chk("ld0_rvalid", {31'd0, bus.p0_rvalid_o}, 32'd1);
        chk("ld0_mis", {31'd0, bus.p0_misalign_o}, 32'd0);

        // Sub-word loads.
        access0("sw100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h80F0_7F01, 32'h0, 1'b0);
        access0("lb101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_007F, 1'b0);
        access0("lbu101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h0000_007F, 1'b0);
        access0("lb102", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'hFFFF_FFF0, 1'b0);
        access0("lbu102", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h0000_00F0, 1'b0);
        access0("lh102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_80F0, 1'b0);
        access0("lhu102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000_80F0, 1'b0);
        access0("lh100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000_7F01, 1'b0);

        // Sub-word stores only touch enabled bytes.
        access0("sw104", 1'b1, 2'b10, 1'b0, 32'h104, 32'h1122_3344, 32'h0, 1'b0);
        access0("sb105", 1'b1, 2'b00, 1'b0, 32'h105, 32'hFFFF_FFAB, 32'h0, 1'b0);
        access0("sh106", 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234_CDEF, 32'h0, 1'b0);
        access0("lw104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCDEF_AB44, 1'b0);

        // Dual lane, different banks.
        drive(0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hA5A5_0001);
        drive(1, 1'b1, 2'b10, 1'b0, 32'h204, 32'h5A5A_0002);
        #1;
        chk("dual_sw_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd3);
        step();
        drive(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
        #1;
        chk("dual_lw_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd3);
        step();
        idle_all();
        chk("dual_rvalid", {30'd0, bus.p1_rvalid_o, bus.p0_rvalid_o}, 32'd3);
        chk("dual_rdata0", bus.p0_rdata_o, 32'hA5A5_0001);
        chk("dual_rdata1", bus.p1_rdata_o, 32'h5A5A_0002);

        // Conflict: p0 store, p1 load to the same word.
`ifdef DMEM_BANK_STATS_EN
        conf_base = conflict_cnt;
        acc_base  = access_cnt;
`endif
        drive(0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        #1;
        chk("cf_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd1);
        step();
        bus.p0_req_i = 1'b0;
        #1;
        chk("cf_p1_ready_n1", {31'd0, bus.p1_ready_o}, 32'd1);
        chk("cf_rvalid_n1", {30'd0, bus.p1_rvalid_o, bus.p0_rvalid_o}, 32'd1);
        step();
        idle_all();
        chk("cf_rvalid_n2", {30'd0, bus.p1_rvalid_o, bus.p0_rvalid_o}, 32'd2);
        chk("cf_rdata_n2", bus.p1_rdata_o, 32'hDEAD_BEEF);
`ifdef DMEM_BANK_STATS_EN
        chk("stat_conflict", conflict_cnt, conf_base + 32'd1);
        chk("stat_access", access_cnt, acc_base + 32'd2);
`endif

        // Reverse conflict: p0 load sees old data, p1 store lands afterwards.
        drive(0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        drive(1, 1'b1, 2'b10, 1'b0, 32'h300, 32'h1234_5678);
        #1;
        chk("rcf_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd1);
        step();
        bus.p0_req_i = 1'b0;
        chk("rcf_old", bus.p0_rdata_o, 32'hDEAD_BEEF);
        step();
        idle_all();
        chk("rcf_p1_rvalid", {31'd0, bus.p1_rvalid_o}, 32'd1);

        // Two loads to the same word are both granted.
        drive(0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        #1;
        chk("ll_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd3);
        step();
        idle_all();
        chk("ll_rdata0", bus.p0_rdata_o, 32'h1234_5678);
        chk("ll_rdata1", bus.p1_rdata_o, 32'h1234_5678);

        // Two loads, same bank, different rows: conflict.
        drive(0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h310, 32'h0);
        #1;
        chk("rowcf_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd1);
        idle_all();
        step();

        // Misalignment.
        access0("mis_lw102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1);
        access0("mis_sh103", 1'b1, 2'b01, 1'b0, 32'h103, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access0("mis_sz11", 1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        access0("mis_keep", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h80F0_7F01, 1'b0);

        // Misaligned p1 never conflicts with a same-bank p0 store.
        drive(0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h0BAD_F00D);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h0);
        #1;
        chk("mis_nocf_ready", {30'd0, bus.p1_ready_o, bus.p0_ready_o}, 32'd3);
        step();
        idle_all();
        chk("mis_nocf_mis1", {31'd0, bus.p1_misalign_o}, 32'd1);

        // Address wrap modulo DEPTH_WORDS*4.
        access0("wrap_sw", 1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFE_F00D, 32'h0, 1'b0);
        access0("wrap_lw", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Reset mid-operation drops the in-flight response.
        drive(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        idle_all();
        chk("mid_rvalid_pre", {31'd0, bus.p0_rvalid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", {31'd0, bus.p0_rvalid_o}, 32'd0);
        chk("mid_rdata", bus.p0_rdata_o, 32'd0);
`ifdef DMEM_BANK_STATS_EN
        chk("mid_stat_rst", conflict_cnt | access_cnt, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
